// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage
// ----------------------------------------------------------------------------
// Instruction-fetch stage: program counter, instruction-memory req/ready
// handshake, one-entry skid buffer and the IF/ID pipeline register.
//
// The stage sits directly behind the hazard detector:
//   data_hazard_n = 0  freezes the PC and IF/ID (stall)
//   if_flush      = 1  redirects the PC and bubbles IF/ID (flush wins over stall)
//
// Internal states:
//   FETCH    - a request for pc is outstanding
//   BUFFERED - a word arrived while stalled and is parked in the skid buffer
//   DRAIN    - a request made before a redirect is still outstanding; its
//              response is stale and gets thrown away
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   data_hazard_n       0 = stall, 1 = proceed
//   if_flush            1 = redirect PC and flush IF/ID
//   branch_taken, jump  redirect source select (jump has priority)
//   branch_target       branch redirect address
//   jump_target         jump redirect address
//   imem_req/imem_addr  fetch request and word-aligned address
//   imem_ready/rdata    response strobe and instruction word
//   pc_out              current fetch PC
//   if_id_instr         IF/ID instruction
//   if_id_pc_plus4      IF/ID PC+4
//   if_id_valid         IF/ID holds a real instruction
//
// Optional build macro IF_PERF_CNT_EN adds two saturating counters:
//   stall_cycles  cycles with data_hazard_n=0 and if_flush=0
//   flush_count   cycles with if_flush=1
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_hazard_n,
    input  logic        if_flush,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        DRAIN    = 2'd2
    } fetch_state_t;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [31:0]  skid_pc_plus4_q, skid_pc_plus4_d;
    logic [31:0]  id_instr_d, id_pc_plus4_d;
    logic         id_valid_d;

    logic [31:0]  redirect_raw;
    logic [31:0]  redirect_pc;
    logic [31:0]  pc_plus4;

    // Jump wins over branch; the low two bits are dropped so the new PC is
    // always word-aligned no matter what the target bus carries.
    assign redirect_raw = jump ? jump_target : branch_target;
    assign redirect_pc  = redirect_raw & ~32'h0000_0003;
    assign pc_plus4     = pc_q + 32'd4;

    // Reset gates the request combinationally so memory never sees a fetch
    // during the reset cycle itself.
    assign imem_req  = !reset && (state_q != BUFFERED);
    // While draining, the address must stay on the stale request until it
    // completes even though pc already points at the redirect target.
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign pc_out    = pc_q;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        drain_addr_d    = drain_addr_q;
        skid_instr_d    = skid_instr_q;
        skid_pc_plus4_d = skid_pc_plus4_q;
        id_instr_d      = if_id_instr;
        id_pc_plus4_d   = if_id_pc_plus4;
        id_valid_d      = if_id_valid;

        case (state_q)
            FETCH: begin
                if (if_flush) begin
                    pc_d       = redirect_pc;
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                    if (!imem_ready) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (!data_hazard_n) begin
                    if (imem_ready) begin
                        skid_instr_d    = imem_rdata;
                        skid_pc_plus4_d = pc_plus4;
                        state_d         = BUFFERED;
                    end
                end else if (imem_ready) begin
                    id_instr_d    = imem_rdata;
                    id_pc_plus4_d = pc_plus4;
                    id_valid_d    = 1'b1;
                    pc_d          = pc_plus4;
                end else begin
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                end
            end

            BUFFERED: begin
                if (if_flush) begin
                    pc_d       = redirect_pc;
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (data_hazard_n) begin
                    id_instr_d    = skid_instr_q;
                    id_pc_plus4_d = skid_pc_plus4_q;
                    id_valid_d    = 1'b1;
                    pc_d          = pc_plus4;
                    state_d       = FETCH;
                end
            end

            DRAIN: begin
                // The stale response ends the drain even if another redirect
                // lands in the same cycle; that redirect only moves pc.
                if (imem_ready) begin
                    state_d = FETCH;
                end
                if (if_flush) begin
                    pc_d       = redirect_pc;
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                end else if (data_hazard_n) begin
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= FETCH;
            pc_q            <= RESET_PC;
            drain_addr_q    <= 32'h0;
            skid_instr_q    <= NOP_INSTR;
            skid_pc_plus4_q <= 32'h0;
            if_id_instr     <= NOP_INSTR;
            if_id_pc_plus4  <= 32'h0;
            if_id_valid     <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            drain_addr_q    <= drain_addr_d;
            skid_instr_q    <= skid_instr_d;
            skid_pc_plus4_q <= skid_pc_plus4_d;
            if_id_instr     <= id_instr_d;
            if_id_pc_plus4  <= id_pc_plus4_d;
            if_id_valid     <= id_valid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Saturating event counters; a flush cycle never counts as a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'h0;
            flush_count  <= 32'h0;
        end else begin
            if (if_flush) begin
                if (flush_count != 32'hFFFF_FFFF) flush_count <= flush_count + 32'd1;
            end else if (!data_hazard_n) begin
                if (stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// tb_if_fetch_stage
// ----------------------------------------------------------------------------
// Directed walk through the fetch scenarios (reset, streaming, stall with
// parked word, branch/jump redirects, drain of a stale response, PC wrap,
// reset during drain) followed by randomized traffic. A transaction-level
// model tracks the PC, a parked-word flag and a stale-request flag and
// predicts every output; every cycle is compared against it.
// ============================================================================
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_hazard_n;
    logic        if_flush;
    logic        branch_taken;
    logic        jump;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_hazard_n (data_hazard_n),
        .if_flush      (if_flush),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .pc_out        (pc_out),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: where the PC points, whether a fetched word is
    // parked waiting for the stall to clear, and whether an outstanding
    // request belongs to an address that a redirect made obsolete.
    logic        m_init = 1'b0;
    logic [31:0] m_pc;
    logic        m_parked;
    logic [31:0] m_park_word;
    logic        m_stale;
    logic [31:0] m_stale_addr;
    logic [31:0] m_instr, m_plus4;
    logic        m_valid;
    logic [31:0] m_stalls, m_flushes;

    logic        seen_req;
    logic [31:0] seen_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_step(input logic rst, dh, fl, bt, jp,
                              input logic [31:0] btt, jtt,
                              input logic rdy, input logic [31:0] rd);
        logic [31:0] tgt;
        if (rst) begin
            m_init = 1'b1; m_pc = 32'h0; m_parked = 1'b0; m_stale = 1'b0;
            m_instr = NOP; m_plus4 = 32'h0; m_valid = 1'b0;
            m_stalls = 32'h0; m_flushes = 32'h0;
            return;
        end
        if (!m_init) return;
        tgt = jp ? jtt : btt;
        tgt = {tgt[31:2], 2'b00};
        if (fl)       m_flushes = sat_inc(m_flushes);
        else if (!dh) m_stalls  = sat_inc(m_stalls);

        if (fl) begin
            // Redirect: any parked word is dropped; a request still in
            // flight for the old stream becomes stale unless it ends now.
            if (!m_stale && !m_parked && !rdy) begin
                m_stale = 1'b1;
                m_stale_addr = m_pc;
            end else if (m_stale && rdy) begin
                m_stale = 1'b0;
            end
            m_parked = 1'b0;
            m_pc = tgt;
            m_instr = NOP; m_valid = 1'b0;
        end else if (m_stale) begin
            if (rdy) m_stale = 1'b0;
            if (dh) begin m_instr = NOP; m_valid = 1'b0; end
        end else if (m_parked) begin
            if (dh) begin
                m_parked = 1'b0;
                m_instr = m_park_word; m_plus4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end else if (!dh) begin
            if (rdy) begin m_parked = 1'b1; m_park_word = rd; end
        end else if (rdy) begin
            m_instr = rd; m_plus4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end else begin
            m_instr = NOP; m_valid = 1'b0;
        end
    endtask

    // One clock: drive at the falling edge, check the request side, advance
    // the model, then check registered outputs at the next falling edge.
    task automatic cycle(input logic rst, dh, fl, bt, jp,
                         input logic [31:0] btt, jtt,
                         input logic rdy, input logic [31:0] rd);
        reset = rst; data_hazard_n = dh; if_flush = fl;
        branch_taken = bt; jump = jp; branch_target = btt; jump_target = jtt;
        imem_ready = rdy; imem_rdata = rd;
        #1;
        seen_req = imem_req;
        seen_addr = imem_addr;
        if (rst) begin
            check("imem_req_in_reset", imem_req, 1'b0);
        end else if (m_init) begin
            check("imem_req", imem_req, !m_parked);
            if (!m_parked) check("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
        end
        model_step(rst, dh, fl, bt, jp, btt, jtt, rdy, rd);
        @(posedge clk);
        @(negedge clk);
        if (m_init) begin
            check("pc_out", pc_out, m_pc);
            check("if_id_valid", if_id_valid, m_valid);
            check("if_id_instr", if_id_instr, m_instr);
            check("if_id_pc_plus4", if_id_pc_plus4, m_plus4);
`ifdef IF_PERF_CNT_EN
            check("stall_cycles", stall_cycles, m_stalls);
            check("flush_count", flush_count, m_flushes);
`endif
        end
    endtask

    // Shorthand: no redirect, proceed/stall and memory response only.
    task automatic run(input logic dh, input logic rdy, input logic [31:0] rd);
        cycle(1'b0, dh, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rdy, rd);
    endtask

    task automatic redirect(input logic dh, bt, jp, input logic [31:0] btt, jtt, input logic rdy);
        cycle(1'b0, dh, 1'b1, bt, jp, btt, jtt, rdy, 32'hBAD0_BAD0);
    endtask

    initial begin
        reset = 1'b1; data_hazard_n = 1'b1; if_flush = 1'b0; branch_taken = 1'b0;
        jump = 1'b0; branch_target = 32'h0; jump_target = 32'h0;
        imem_ready = 1'b0; imem_rdata = 32'h0;
        @(negedge clk);

        // Reset state
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_valid", if_id_valid, 1'b0);
        check("rst_instr", if_id_instr, NOP);

        // 1: streaming, one instruction per cycle
        run(1'b1, 1'b1, 32'h2008_0005);
        check("t1_addr0", seen_addr, 32'h0);
        check("t1_instr0", if_id_instr, 32'h2008_0005);
        check("t1_plus4_0", if_id_pc_plus4, 32'h4);
        check("t1_valid0", if_id_valid, 1'b1);
        run(1'b1, 1'b1, 32'h2009_0003);
        check("t1_addr1", seen_addr, 32'h4);
        check("t1_plus4_1", if_id_pc_plus4, 32'h8);
        check("t1_pc", pc_out, 32'h8);

        // 2: stall with ready -> word parked, request dropped, then released
        run(1'b0, 1'b1, 32'hDEAD_0001);
        check("t2_pc_a", pc_out, 32'h8);
        check("t2_hold", if_id_instr, 32'h2009_0003);
        run(1'b0, 1'b1, 32'h7777_7777);
        check("t2_req_off", seen_req, 1'b0);
        run(1'b0, 1'b1, 32'h7777_7777);
        check("t2_req_off2", seen_req, 1'b0);
        check("t2_pc_b", pc_out, 32'h8);
        run(1'b1, 1'b0, 32'h0);
        check("t2_release", if_id_instr, 32'hDEAD_0001);
        check("t2_pc_c", pc_out, 32'hC);

        // 3: branch flush with ready in the same cycle
        redirect(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
        check("t3_pc", pc_out, 32'h40);
        check("t3_valid", if_id_valid, 1'b0);
        check("t3_instr", if_id_instr, NOP);

        // 4: redirect while a request at 0x10 is still pending -> drain
        redirect(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        run(1'b1, 1'b0, 32'h0);
        check("t4_addr_a", seen_addr, 32'h10);
        redirect(1'b1, 1'b0, 1'b1, 32'h0, 32'h83, 1'b0);
        check("t4_pc", pc_out, 32'h80);
        run(1'b1, 1'b0, 32'h0);
        check("t4_addr_b", seen_addr, 32'h10);
        run(1'b1, 1'b1, 32'h0BAD_0BAD);
        check("t4_addr_c", seen_addr, 32'h10);
        check("t4_discard", if_id_valid, 1'b0);
        run(1'b1, 1'b1, 32'h1111_2222);
        check("t4_addr_d", seen_addr, 32'h80);
        check("t4_instr", if_id_instr, 32'h1111_2222);

        // 5: stall and flush together, jump beats branch
        redirect(1'b0, 1'b1, 1'b1, 32'h100, 32'h200, 1'b1);
        check("t5_pc", pc_out, 32'h200);

        // PC wrap and target alignment
        redirect(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b1);
        check("wrap_align", pc_out, 32'hFFFF_FFFC);
        run(1'b1, 1'b1, 32'h5555_AAAA);
        check("wrap_pc", pc_out, 32'h0);
        check("wrap_plus4", if_id_pc_plus4, 32'h0);

        // 6: reset in the middle of a drain
        redirect(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0);
        run(1'b1, 1'b0, 32'h0);
        check("t6_drain_addr", seen_addr, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("t6_pc", pc_out, 32'h0);
        check("t6_valid", if_id_valid, 1'b0);
`ifdef IF_PERF_CNT_EN
        check("t6_stalls", stall_cycles, 32'h0);
        check("t6_flushes", flush_count, 32'h0);
`endif
        run(1'b1, 1'b0, 32'h0);
        check("t6_fetch_req", seen_req, 1'b1);
        check("t6_fetch_addr", seen_addr, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 6) == 0),
                  1'(($urandom & 32'h1)),
                  1'(($urandom & 32'h1)),
                  $urandom, $urandom,
                  ($urandom_range(0, 9) < 6),
                  $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
